dsm2_core: RTL
==============

Name: dsm2_core

Overview:
- Second-order, 1-bit delta-sigma modulator core.
- Consumes PCM samples from the upstream interpolator over a valid/ready handshake and holds each sample for OSR clocks.
- Consumes the dither word produced by the team's LFSR dither generator and adds it ahead of the quantizer.
- Emits one bitstream bit per clock to the output driver.

Parameters:
- DATA_W, 16, width of signed PCM input sample.
- DITH_W, 19, width of signed dither input word (from dither generator).
- ACC_W, 20, width of each signed integrator; must be > DATA_W+1.
- OSR, 64, clocks per input sample; must be >= 2.
- DITH_SHIFT, 4, arithmetic right shift applied to dither before injection.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- din  in  DATA_W  signed PCM sample.
- din_valid  in  1  din holds a valid sample.
- din_ready  out  1  core accepts din this cycle.
- dith_i  in  DITH_W  signed dither word, sampled every clock.
- dout  out  1  modulator bitstream (1 = +FS, 0 = -FS).
- underrun  out  1  one-cycle pulse: no sample was available at the boundary.
- sat_flag  out  1  sticky: some integrator has saturated since reset.

Behaviour:
Reset:
- Reset has priority over all other activity. It applies at the next clock edge, including mid-sample.
- Reset values: ph=0, x_hold=0, int1=0, int2=0, dout=0, underrun=0, sat_flag=0.

Phase counter and sample hold:
- ph runs 0..OSR-1, increments every cycle and wraps from OSR-1 to 0.
- din_ready = (ph==OSR-1) && !reset. It is combinational and high for exactly 1 of every OSR cycles.
- Transfer occurs when din_valid && din_ready. x_hold <= din, and the new sample is used by int1 from the next cycle.
- If ph==OSR-1 and !din_valid: underrun is 1 the next cycle, and x_hold keeps the previous sample.
- din_valid outside the ready cycle is ignored. The upstream holds data until ready.

Loop, evaluated every cycle from the current registers:
- FS = 2^(DATA_W-1); fb = dout ? +FS : -FS.
- int1 <= sat(int1 + sext(x_hold) - fb).
- int2 <= sat(int2 + int1 - fb). This uses the old int1, so there is one register of delay between stages.
- sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Sums are computed in ACC_W+2 bits, so no intermediate wrap-around is permitted.
- When a clamp is active, sat_flag <= 1 and stays set until reset.

Quantizer:
- d = sext(dith_i) >>> DITH_SHIFT, with sign extension to ACC_W+2 bits.
- dout <= ((int2 + d) >= 0).
- Latency: a dith_i change affects dout at the next edge. A sample transfer first affects dout 3 edges later (x_hold, int1, int2, then dout).

Optional Feature:
- Macro: DSM_DITHER_EN.
- Defined: dither injected exactly as specified above.
- Undefined: d is 0, dith_i is unused, and the quantizer is dout <= (int2 >= 0). All other behaviour is identical.

Test Plan:
1. Reset then idle: hold reset 3 cycles, din_valid=0.
   - After reset, dout=0, sat_flag=0, and ph-driven din_ready first rises on cycle 63.
   - underrun pulses on cycle 64 and then every 64 cycles.
2. Handshake: din_valid held high with din incrementing on every accepted transfer.
   - Exactly one transfer per 64 cycles; no sample is dropped or duplicated (scoreboard over 32 samples).
3. DC density: dither disabled, din=0 for 4096 cycles → ones count 2048±4.
   - din=+8192 (FS/4) → ones count 2560±8.
   - din=-16384 (-FS/2) → ones count 1024±8.
4. Dither effect: DSM_DITHER_EN on, din=0, dith_i random → ones density 50%±1%, sat_flag stays 0.
   - Bitstream differs from the no-dither run of scenario 3 within 16 cycles.
5. Saturation: din=+32767 for 2000 cycles → sat_flag=1; int1 and int2 never wrap sign (monitor).
   - Then din=0 → ones density returns to 50%±2% within 512 cycles.
6. Mid-operation reset: pulse reset at ph=30 during active data → next cycle all registers are at reset values.
   - din_ready next rises exactly 64 cycles after reset deasserts.

Source files
------------

// File: rtl/dsm2_core.sv
// dsm2_core: second-order 1-bit delta-sigma modulator with a held PCM sample and a sticky saturation flag.
// Define DSM_DITHER_EN to add the shifted dither word ahead of the quantizer.
module dsm2_core #(
    parameter int DATA_W     = 16,
    parameter int DITH_W     = 19,
    parameter int ACC_W      = 20,
    parameter int OSR        = 64,
    parameter int DITH_SHIFT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic signed [DITH_W-1:0] dith_i,
    output logic                     dout,
    output logic                     underrun,
    output logic                     sat_flag
);
    localparam int PH_W = $clog2(OSR);
    localparam int S_W  = ACC_W + 2;
    localparam logic signed [S_W-1:0] FS   = S_W'(2 ** (DATA_W - 1));
    localparam logic signed [S_W-1:0] AMAX = S_W'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [S_W-1:0] AMIN = -AMAX - S_W'(1);

    logic [PH_W-1:0]          ph;
    logic signed [DATA_W-1:0] x_hold;
    logic signed [ACC_W-1:0]  int1, int2, n1, n2;
    logic signed [S_W-1:0]    fb, s1, s2, d, q;
    logic                     c1, c2;

    assign din_ready = (ph == PH_W'(OSR - 1)) && !reset;

`ifdef DSM_DITHER_EN
    assign d = S_W'(dith_i) >>> DITH_SHIFT;
`else
    logic unused_dith;
    assign unused_dith = ^dith_i;
    assign d = '0;
`endif

    // Both stages read the old int1, giving one register of delay between them.
    always_comb begin
        fb = dout ? FS : -FS;
        s1 = S_W'(int1) + S_W'(x_hold) - fb;
        s2 = S_W'(int2) + S_W'(int1) - fb;
        q  = S_W'(int2) + d;
        c1 = (s1 > AMAX) || (s1 < AMIN);
        c2 = (s2 > AMAX) || (s2 < AMIN);
        n1 = s1 > AMAX ? ACC_W'(AMAX) : s1 < AMIN ? ACC_W'(AMIN) : ACC_W'(s1);
        n2 = s2 > AMAX ? ACC_W'(AMAX) : s2 < AMIN ? ACC_W'(AMIN) : ACC_W'(s2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ph       <= '0;
            x_hold   <= '0;
            int1     <= '0;
            int2     <= '0;
            dout     <= 1'b0;
            underrun <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            ph       <= din_ready ? '0 : ph + PH_W'(1);
            if (din_ready && din_valid) x_hold <= din;
            underrun <= din_ready && !din_valid;
            int1     <= n1;
            int2     <= n2;
            dout     <= !q[S_W-1];
            if (c1 || c2) sat_flag <= 1'b1;
        end
    end
endmodule
